// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial bit-pattern transmitter.
// Latches a pattern word and shifts it out MSB-first on s_out, one bit per clk. The pattern
// is repeated reps times, with GAP_CYCLES idle cycles between repetitions. A one-cycle done
// pulse closes each burst.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high reset
//   start      burst request, accepted only when no burst is running
//   pattern    bits to send; pattern[len-1:0] is sent, MSB first
//   len        bits per repetition; values above MAX_LEN clamp to MAX_LEN
//   reps       number of repetitions
//   s_out      registered serial data
//   bit_valid  high in every cycle s_out carries a pattern bit
//   busy       high from the cycle after start is accepted through the done cycle
//   done       one-cycle burst completion pulse
module seq_pattern_tx #(
  parameter int unsigned MAX_LEN    = 8,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [CNT_W-1:0]   reps,
  output logic               s_out,
  output logic               bit_valid,
  output logic               busy,
  output logic               done
);

  localparam int unsigned      GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GapLoad = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [LEN_W-1:0] MaxLen  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LenOne  = LEN_W'(1);
  localparam logic [CNT_W-1:0] RepOne  = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;

  state_e             state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   top_q;   // index of the first (MSB) bit of a repetition
  logic [LEN_W-1:0]   idx_q;   // index of the bit currently on s_out
  logic [CNT_W-1:0]   rep_q;   // repetitions still to send, including the current one
  logic [GAP_W-1:0]   gap_q;

  logic [LEN_W-1:0]   len_c;
  logic               accept;

  always_comb begin
    len_c = (len > MaxLen) ? MaxLen : len;
  end

  // Accepting in StDone lets a held start chain bursts with busy staying high.
  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  function automatic logic pick_bit(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] i);
    logic [MAX_LEN-1:0] t;
    t = p >> i;
    return t[0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      top_q     <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      s_out     <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (accept) begin
      pat_q <= pattern;
      top_q <= len_c - LenOne;
      rep_q <= reps;
      gap_q <= '0;
      busy  <= 1'b1;
      if ((len_c == '0) || (reps == '0)) begin
        state_q   <= StDone;
        idx_q     <= '0;
        s_out     <= 1'b0;
        bit_valid <= 1'b0;
        done      <= 1'b1;
      end else begin
        state_q   <= StShift;
        idx_q     <= len_c - LenOne;
        s_out     <= pick_bit(pattern, len_c - LenOne);
        bit_valid <= 1'b1;
        done      <= 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          s_out     <= 1'b0;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
        StShift: begin
          if (idx_q != '0) begin
            idx_q <= idx_q - LenOne;
            s_out <= pick_bit(pat_q, idx_q - LenOne);
          end else if (rep_q > RepOne) begin
            rep_q <= rep_q - RepOne;
            if (GAP_CYCLES > 0) begin
              state_q   <= StGap;
              gap_q     <= GapLoad;
              s_out     <= 1'b0;
              bit_valid <= 1'b0;
            end else begin
              idx_q <= top_q;
              s_out <= pick_bit(pat_q, top_q);
            end
          end else begin
            state_q   <= StDone;
            s_out     <= 1'b0;
            bit_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        StGap: begin
          if (gap_q == '0) begin
            state_q   <= StShift;
            idx_q     <= top_q;
            s_out     <= pick_bit(pat_q, top_q);
            bit_valid <= 1'b1;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        StDone: begin
          state_q   <= StIdle;
          s_out     <= 1'b0;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: per-cycle expected {s_out, bit_valid, busy, done} words are
// queued when a burst is started and popped one per clock against the DUT outputs.
module tb_seq_pattern_tx;

  localparam int unsigned MaxLen = 8;
  localparam int unsigned CntW   = 8;
  localparam int unsigned Gap    = 2;
  localparam int unsigned LenW   = $clog2(MaxLen + 1);

  logic              clk;
  logic              reset;
  logic              start;
  logic [MaxLen-1:0] pattern;
  logic [LenW-1:0]   len;
  logic [CntW-1:0]   reps;
  logic              s_out;
  logic              bit_valid;
  logic              busy;
  logic              done;

  int checks = 0;
  int passes = 0;

  logic [3:0] exp_q[$];

  seq_pattern_tx #(
    .MAX_LEN   (MaxLen),
    .CNT_W     (CntW),
    .GAP_CYCLES(Gap),
    .LEN_W     (LenW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pattern  (pattern),
    .len      (len),
    .reps     (reps),
    .s_out    (s_out),
    .bit_valid(bit_valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] expv);
    logic [3:0] obs;
    obs = {s_out, bit_valid, busy, done};
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed {s_out,bv,busy,done}=%b expected %b", tag, obs, expv);
  endtask

  // Expected output words for one burst, one entry per cycle after start is accepted.
  task automatic push_burst(input logic [7:0] p, input int l, input int r, input bit idle);
    int lc;
    lc = (l > int'(MaxLen)) ? int'(MaxLen) : l;
    if (lc == 0 || r == 0) begin
      exp_q.push_back(4'b0011);
    end else begin
      for (int rr = 0; rr < r; rr++) begin
        for (int i = lc - 1; i >= 0; i--) exp_q.push_back({p[i], 3'b110});
        if (rr < r - 1) for (int g = 0; g < int'(Gap); g++) exp_q.push_back(4'b0010);
      end
      exp_q.push_back(4'b0011);
    end
    if (idle) exp_q.push_back(4'b0000);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      check($sformatf("%s[%0d]", tag, n), exp_q.pop_front());
      n++;
      tick();
    end
  endtask

  task automatic go(input logic [7:0] p, input int l, input int r);
    pattern = p;
    len     = LenW'(l);
    reps    = CntW'(r);
    start   = 1'b1;
    push_burst(p, l, r, 1'b1);
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    pattern = '0;
    len     = '0;
    reps    = '0;
    tick();
    tick();
    check("reset", 4'b0000);
    reset = 1'b0;
    tick();
    check("idle", 4'b0000);

    // Single repetition, 3'b100.
    go(8'h04, 3, 1);
    drain("single");

    // Three repetitions of 2'b10 with gaps.
    go(8'h02, 2, 3);
    drain("gapped");

    // Degenerate bursts.
    go(8'hFF, 0, 5);
    drain("len0");
    go(8'hFF, 3, 0);
    drain("reps0");

    // start pulsed mid-burst with different settings must be ignored.
    go(8'h04, 3, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      check($sformatf("midstart[%0d]", i), exp_q.pop_front());
      if (i == 1) begin
        start   = 1'b1;
        pattern = 8'hFF;
        len     = LenW'(5);
        reps    = CntW'(2);
      end
      if (i == 2) start = 1'b0;
      tick();
    end

    // Reset on the second bit of the gapped burst.
    go(8'h02, 2, 3);
    check("rst_bit0", exp_q.pop_front());
    tick();
    check("rst_bit1", exp_q.pop_front());
    exp_q.delete();
    reset = 1'b1;
    tick();
    check("rst_clear", 4'b0000);
    reset = 1'b0;
    tick();
    check("rst_nodone", 4'b0000);
    go(8'h02, 2, 3);
    drain("after_rst");

    // len above MAX_LEN clamps.
    go(8'hA5, 15, 1);
    drain("clamp");

    // start held high: two bursts back to back, busy never drops between them.
    pattern = 8'h04;
    len     = LenW'(3);
    reps    = CntW'(1);
    start   = 1'b1;
    push_burst(8'h04, 3, 1, 1'b0);
    push_burst(8'h04, 3, 1, 1'b1);
    tick();
    for (int i = 0; exp_q.size() > 0; i++) begin
      check($sformatf("held[%0d]", i), exp_q.pop_front());
      if (i == 4) start = 1'b0;
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
